// File: rtl/ft601_tx_framer.sv
// ft601_tx_framer
// Packs a 32-bit sample stream into packets of the form header, 1..MAX_WORDS payload
// words, trailer. Each packet is written into the FT601 write buffer and pushed to the
// read side. The next packet does not start until the buffer has drained completely,
// so the buffer only ever holds one packet.
module ft601_tx_framer #(
   parameter int MAX_WORDS = 1024,  // payload words per packet, 1..4092
   parameter int TIMEOUT   = 4096   // idle cycles before a partial packet is closed, >= 2
) (
   input  logic        wr_clk,
   input  logic        wr_reset,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [35:0] wr_data,
   output logic        wr_en,
   output logic        wr_push,
   input  logic        writeable,
   input  logic        almost_unwriteable,
   output logic [15:0] pkt_seq,
   output logic        busy,
   output logic        timeout_flush,
   output logic        early_close
);

   // idle_cnt never needs to hold more than TIMEOUT-2
   localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [15:0] HDR_MARK = 16'hA55A;
   localparam logic [15:0] TRL_MARK = 16'h5AA5;
   localparam logic [3:0]  BYTE_EN  = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PAY,
      TRL,
      DRN_LO,
      DRN_HI
   } state_t;

   state_t            state, state_nxt;
   logic [11:0]       pay_cnt, pay_cnt_nxt;
   logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
   logic [15:0]       pkt_seq_nxt;

   // State and counter registers; reset abandons any packet in flight.
   // NOTE: sequential state is updated only with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge wr_clk) begin
      if (wr_reset) begin
         state    <= IDLE;
         pay_cnt  <= '0;
         idle_cnt <= '0;
         pkt_seq  <= '0;
      end else begin
         state    <= state_nxt;
         pay_cnt  <= pay_cnt_nxt;
         idle_cnt <= idle_cnt_nxt;
         pkt_seq  <= pkt_seq_nxt;
      end
   end

   // Next-state logic and buffer-side outputs, combinational so the buffer sees them with no added latency.
   // NOTE: every signal assigned here gets a default first; a path that skipped one
   // would otherwise infer a latch.
   always_comb begin
      state_nxt     = state;
      pay_cnt_nxt   = pay_cnt;
      idle_cnt_nxt  = idle_cnt;
      pkt_seq_nxt   = pkt_seq;
      s_ready       = 1'b0;
      wr_en         = 1'b0;
      wr_push       = 1'b0;
      wr_data       = '0;
      timeout_flush = 1'b0;
      early_close   = 1'b0;

      unique case (state)
         IDLE: begin
            if (s_valid && writeable) state_nxt = HDR;
         end

         HDR: begin
            wr_en        = 1'b1;
            wr_data      = {BYTE_EN, HDR_MARK, pkt_seq};
            pay_cnt_nxt  = '0;
            idle_cnt_nxt = '0;
            state_nxt    = PAY;
         end

         PAY: begin
            if (almost_unwriteable) begin
               // buffer nearly full: close now so the trailer still fits
               early_close = 1'b1;
               state_nxt   = TRL;
            end else begin
               s_ready = 1'b1;
               if (s_valid) begin
                  wr_en        = 1'b1;
                  wr_data      = {BYTE_EN, s_data};
                  pay_cnt_nxt  = pay_cnt + 12'd1;
                  idle_cnt_nxt = '0;
                  if (pay_cnt == 12'(MAX_WORDS - 1)) state_nxt = TRL;
               end else if (idle_cnt == IDLE_W'(TIMEOUT - 2)) begin
                  // this is idle cycle TIMEOUT-1, so the trailer lands TIMEOUT cycles after the last accept
                  timeout_flush = 1'b1;
                  state_nxt     = TRL;
               end else begin
                  idle_cnt_nxt = idle_cnt + IDLE_W'(1);
               end
            end
         end

         TRL: begin
            wr_en       = 1'b1;
            wr_push     = 1'b1;
            wr_data     = {BYTE_EN, TRL_MARK, 4'h0, pay_cnt};
            pkt_seq_nxt = pkt_seq + 16'd1;
            state_nxt   = DRN_LO;
         end

         // writeable must first be seen low, so a level left over from before the push is not mistaken for drained
         DRN_LO: begin
            if (!writeable) state_nxt = DRN_HI;
         end

         DRN_HI: begin
            if (writeable) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule
